level_sequencer: RTL and testbench
==================================

# level_sequencer

Game-level controller sitting directly downstream of the destination-rectangle stage. It consumes that stage's one-cycle `level_complete` pulse, plays a blinking "celebrate" interval, advances a level index, and drives the next level's destination position, colour and visibility back into the rectangle stage. It also emits a player-reload pulse with the level's player start position, and flags game completion.

## Interface
- `NUM_LEVELS`, 8, number of levels; legal range 2..16.
- `CELEBRATE_TICKS`, 32, frame ticks spent in CELEBRATE; legal range 1..255.
- `BLINK_TICKS`, 8, frame ticks per visibility toggle during CELEBRATE; legal range 1..255.
- `TIMEOUT_TICKS`, 1800, per-level time limit in frame ticks; only used with the macro; legal range 1..65535.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  one-cycle frame-rate strobe.
- `start`  in  1  one-cycle start/restart pulse.
- `level_complete`  in  1  one-cycle pulse from the destination stage.
- `level`  out  4  current level index.
- `dest_vStartPos`  out  12  destination rectangle vertical position.
- `dest_hStartPos`  out  12  destination rectangle horizontal position.
- `dest_color`  out  4  destination rectangle colour.
- `dest_visible`  out  1  destination rectangle visibility.
- `player_vStart`  out  12  player start vertical position for the current level.
- `player_hStart`  out  12  player start horizontal position for the current level.
- `player_load`  out  1  one-cycle pulse: player block reloads its start position.
- `game_won`  out  1  high in WIN.
- `time_left`  out  16  ticks remaining in the current level.

## Operation
- States: IDLE, PLAY, CELEBRATE, LOAD, WIN.
  - Reset state: IDLE.
  - The encoding is shared through the package.
- Position, colour and start outputs are the level-table entry indexed by `level`. They are combinational from the table and the registered `level`.
- **IDLE**
  - `dest_visible` is 0.
  - On `start`: `level` is set to 0, `player_load` pulses, and the FSM goes to PLAY.
- **PLAY**
  - `dest_visible` is 1.
  - On `level_complete`: clear the tick counter, go to CELEBRATE.
  - `start` is ignored in PLAY.
- **CELEBRATE**
  - The tick counter increments on each `tick`.
  - `dest_visible` toggles after every `BLINK_TICKS` ticks, starting from 1.
  - When the counter reaches `CELEBRATE_TICKS`, go to LOAD.
  - `level_complete` is ignored.
- **LOAD** (exactly one cycle)
  - If `level == NUM_LEVELS-1`: go to WIN.
  - Otherwise: `level` increments by 1, `player_load` pulses, and the FSM goes to PLAY.
- **WIN**
  - `game_won` is 1 and `dest_visible` is 0.
  - On `start`: `level` is set to 0, `player_load` pulses, `game_won` clears, and the FSM goes to PLAY.
- `level_complete` is accepted only in PLAY. Pulses arriving in any other state are dropped, not queued.
- `level` saturates at `NUM_LEVELS-1` and never wraps.

## Timing
- Reset values:
  - `level` = 0 and `dest_visible` = 0.
  - `player_load`, `game_won` and the tick counter are all 0.
  - `time_left` = 0.
  - Positions and colour show table entry 0.
- All outputs except the table lookups are registered.
- `player_load` is high for exactly one clk, in the cycle after the edge that accepts `start` or completes LOAD. `level` already holds its new value in that same cycle.
- Latency from `level_complete` to CELEBRATE: 1 clk.
- From entering CELEBRATE to entering PLAY of the next level: `CELEBRATE_TICKS` ticks + 1 clk for LOAD.
- `tick` and `level_complete` in the same PLAY cycle: `level_complete` wins.
- `rst` asserted mid-CELEBRATE or mid-LOAD: immediate return to IDLE with reset values. No `player_load` is issued.

## Configuration
- `LEVEL_SEQ_TIMEOUT_EN` defined:
  - `time_left` is loaded with `TIMEOUT_TICKS` on every `player_load`.
  - It decrements on each `tick` while in PLAY.
  - If it reaches 0 while in PLAY, the level restarts: `player_load` pulses, `time_left` reloads, `level` is unchanged, and the FSM stays in PLAY.
  - `level_complete` in the same cycle as expiry wins; no restart occurs.
- `LEVEL_SEQ_TIMEOUT_EN` undefined:
  - No timer logic is built.
  - `time_left` is tied to 0.

## Structure
- Shared package `level_seq_pkg` contains:
  - the state enum;
  - a `level_entry_t` typedef: dest v/h (12 bits each), colour (4 bits), player v/h start (12 bits each);
  - the constant level table, 16 entries.
- Sub-module `level_rom`: combinational lookup from `level` to `level_entry_t`. It is separable so the table can be replaced without touching the FSM.

## Test plan
- Reset, then `start` → `player_load` high for 1 clk, `level`=0, `dest_visible`=1. Outputs equal table entry 0.
- In PLAY at level 0, pulse `level_complete`; run with `CELEBRATE_TICKS`=4 and `BLINK_TICKS`=2 → `dest_visible` follows 1,1,0,0 across ticks. Then LOAD, `level`=1, `player_load` pulses, `dest_*` equal entry 1.
- At `level`=NUM_LEVELS-1, complete → WIN with `game_won`=1 and `dest_visible`=0. `start` → `level`=0 and `game_won`=0.
- Pulse `level_complete` during CELEBRATE, and `start` during PLAY → both ignored; level sequence unchanged.
- Assert `rst` during CELEBRATE → IDLE next cycle, all outputs at reset values, no `player_load`.
- With `LEVEL_SEQ_TIMEOUT_EN` and `TIMEOUT_TICKS`=3:
  - 3 ticks with no completion → `player_load` pulses, `level` unchanged, `time_left`=3.
  - Completion coincident with expiry → CELEBRATE, no restart.

Source files
------------

// File: rtl/level_seq_pkg.sv
// ============================================================================
// Module  : level_seq_pkg
// Brief   : Shared FSM state encoding, level-entry record and the 16-entry level table.
// Revision: 1.0
// ============================================================================
`default_nettype none

package level_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_CELEBRATE = 3'd2,
        ST_LOAD      = 3'd3,
        ST_WIN       = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [11:0] dest_v;
        logic [11:0] dest_h;
        logic [3:0]  color;
        logic [11:0] player_v;
        logic [11:0] player_h;
    } level_entry_t;

    localparam int c_NUM_TABLE_ENTRIES = 16;

    // Field order: dest v, dest h, colour, player start v, player start h.
    localparam level_entry_t c_level_table [0:c_NUM_TABLE_ENTRIES-1] = '{
        '{12'd100, 12'd600, 4'h1, 12'd400, 12'd50 },
        '{12'd80,  12'd700, 4'h2, 12'd420, 12'd60 },
        '{12'd60,  12'd500, 4'h3, 12'd300, 12'd100},
        '{12'd200, 12'd650, 4'h4, 12'd450, 12'd80 },
        '{12'd40,  12'd300, 4'h5, 12'd500, 12'd700},
        '{12'd300, 12'd100, 4'h6, 12'd50,  12'd600},
        '{12'd120, 12'd720, 4'h7, 12'd480, 12'd20 },
        '{12'd20,  12'd20,  4'h8, 12'd460, 12'd740},
        '{12'd250, 12'd400, 4'h9, 12'd100, 12'd100},
        '{12'd350, 12'd200, 4'hA, 12'd30,  12'd700},
        '{12'd150, 12'd550, 4'hB, 12'd470, 12'd300},
        '{12'd400, 12'd50,  4'hC, 12'd10,  12'd10 },
        '{12'd50,  12'd750, 4'hD, 12'd450, 12'd400},
        '{12'd270, 12'd330, 4'hE, 12'd120, 12'd620},
        '{12'd180, 12'd620, 4'hF, 12'd440, 12'd90 },
        '{12'd10,  12'd10,  4'hF, 12'd460, 12'd760}
    };

endpackage

`default_nettype wire

// File: rtl/level_rom.sv
// ============================================================================
// Module  : level_rom
// Brief   : Combinational level-table lookup; replaceable without touching the FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module level_rom
    import level_seq_pkg::*;
(
    input  logic [3:0]   level,
    output level_entry_t entry
);

    assign entry = c_level_table[level];

endmodule

`default_nettype wire

// File: rtl/level_sequencer.sv
// ============================================================================
// Module  : level_sequencer
// Brief   : Level FSM (IDLE/PLAY/CELEBRATE/LOAD/WIN) driving the destination stage.
//           Optional per-level timeout built when LEVEL_SEQ_TIMEOUT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module level_sequencer
    import level_seq_pkg::*;
#(
    parameter int NUM_LEVELS      = 8,
    parameter int CELEBRATE_TICKS = 32,
    parameter int BLINK_TICKS     = 8,
    parameter int TIMEOUT_TICKS   = 1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        level_complete,
    output logic [3:0]  level,
    output logic [11:0] dest_vStartPos,
    output logic [11:0] dest_hStartPos,
    output logic [3:0]  dest_color,
    output logic        dest_visible,
    output logic [11:0] player_vStart,
    output logic [11:0] player_hStart,
    output logic        player_load,
    output logic        game_won,
    output logic [15:0] time_left
);

    localparam logic [3:0] c_LAST_LEVEL = 4'(NUM_LEVELS - 1);
    localparam logic [7:0] c_CEL_LAST   = 8'(CELEBRATE_TICKS - 1);
    localparam logic [7:0] c_BLINK_LAST = 8'(BLINK_TICKS - 1);

    if (NUM_LEVELS < 2 || NUM_LEVELS > 16) begin : g_bad_num_levels
        $error("level_sequencer: NUM_LEVELS out of range 2..16");
    end
    if (CELEBRATE_TICKS < 1 || CELEBRATE_TICKS > 255) begin : g_bad_celebrate
        $error("level_sequencer: CELEBRATE_TICKS out of range 1..255");
    end
    if (BLINK_TICKS < 1 || BLINK_TICKS > 255) begin : g_bad_blink
        $error("level_sequencer: BLINK_TICKS out of range 1..255");
    end
    if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 65535) begin : g_bad_timeout
        $error("level_sequencer: TIMEOUT_TICKS out of range 1..65535");
    end

    seq_state_t  state_q, state_d;
    logic [3:0]  level_q, level_d;
    logic [7:0]  cel_cnt_q, cel_cnt_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        vis_q, vis_d;
    logic        player_load_q, player_load_d;
    logic        game_won_q, game_won_d;
    level_entry_t entry;

`ifdef LEVEL_SEQ_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_TICKS);
    logic [15:0] time_left_q, time_left_d;
    logic        w_expire;

    // Expiry is the tick that would take the counter to zero.
    assign w_expire = (state_q == ST_PLAY) && tick && !level_complete &&
                      (time_left_q <= 16'd1);
`endif

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        cel_cnt_d     = cel_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        vis_d         = vis_q;
        player_load_d = 1'b0;
        game_won_d    = game_won_q;

        case (state_q)
            ST_IDLE, ST_WIN: begin
                if (start) begin
                    state_d       = ST_PLAY;
                    level_d       = 4'd0;
                    player_load_d = 1'b1;
                    game_won_d    = 1'b0;
                    vis_d         = 1'b1;
                end
            end
            ST_PLAY: begin
                if (level_complete) begin
                    state_d     = ST_CELEBRATE;
                    cel_cnt_d   = 8'd0;
                    blink_cnt_d = 8'd0;
                    vis_d       = 1'b1;
                end
`ifdef LEVEL_SEQ_TIMEOUT_EN
                else if (w_expire) begin
                    player_load_d = 1'b1;
                end
`endif
            end
            ST_CELEBRATE: begin
                if (tick) begin
                    cel_cnt_d = cel_cnt_q + 8'd1;
                    if (blink_cnt_q == c_BLINK_LAST) begin
                        blink_cnt_d = 8'd0;
                        vis_d       = ~vis_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 8'd1;
                    end
                    if (cel_cnt_q == c_CEL_LAST) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (level_q == c_LAST_LEVEL) begin
                    state_d    = ST_WIN;
                    game_won_d = 1'b1;
                    vis_d      = 1'b0;
                end else begin
                    state_d       = ST_PLAY;
                    level_d       = level_q + 4'd1;
                    player_load_d = 1'b1;
                    vis_d         = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vis_d   = 1'b0;
            end
        endcase
    end

`ifdef LEVEL_SEQ_TIMEOUT_EN
    always_comb begin
        time_left_d = time_left_q;
        if (player_load_d) begin
            time_left_d = c_TIMEOUT;
        end else if (state_q == ST_PLAY && tick && !level_complete) begin
            time_left_d = time_left_q - 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            level_q       <= 4'd0;
            cel_cnt_q     <= 8'd0;
            blink_cnt_q   <= 8'd0;
            vis_q         <= 1'b0;
            player_load_q <= 1'b0;
            game_won_q    <= 1'b0;
`ifdef LEVEL_SEQ_TIMEOUT_EN
            time_left_q   <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            cel_cnt_q     <= cel_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            vis_q         <= vis_d;
            player_load_q <= player_load_d;
            game_won_q    <= game_won_d;
`ifdef LEVEL_SEQ_TIMEOUT_EN
            time_left_q   <= time_left_d;
`endif
        end
    end

    level_rom u_level_rom (
        .level (level_q),
        .entry (entry)
    );

    assign level          = level_q;
    assign dest_vStartPos = entry.dest_v;
    assign dest_hStartPos = entry.dest_h;
    assign dest_color     = entry.color;
    assign player_vStart  = entry.player_v;
    assign player_hStart  = entry.player_h;
    assign dest_visible   = vis_q;
    assign player_load    = player_load_q;
    assign game_won       = game_won_q;

`ifdef LEVEL_SEQ_TIMEOUT_EN
    assign time_left = time_left_q;
`else
    assign time_left = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_level_sequencer.sv
// ============================================================================
// Module  : tb_level_sequencer
// Brief   : Directed self-checking bench for level_sequencer (3 levels, short celebrate).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_level_sequencer;

    localparam int NUM_LEVELS      = 3;
    localparam int CELEBRATE_TICKS = 4;
    localparam int BLINK_TICKS     = 2;
    localparam int TIMEOUT_TICKS   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        start;
    logic        level_complete;
    logic [3:0]  level;
    logic [11:0] dest_vStartPos;
    logic [11:0] dest_hStartPos;
    logic [3:0]  dest_color;
    logic        dest_visible;
    logic [11:0] player_vStart;
    logic [11:0] player_hStart;
    logic        player_load;
    logic        game_won;
    logic [15:0] time_left;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    level_sequencer #(
        .NUM_LEVELS      (NUM_LEVELS),
        .CELEBRATE_TICKS (CELEBRATE_TICKS),
        .BLINK_TICKS     (BLINK_TICKS),
        .TIMEOUT_TICKS   (TIMEOUT_TICKS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .start          (start),
        .level_complete (level_complete),
        .level          (level),
        .dest_vStartPos (dest_vStartPos),
        .dest_hStartPos (dest_hStartPos),
        .dest_color     (dest_color),
        .dest_visible   (dest_visible),
        .player_vStart  (player_vStart),
        .player_hStart  (player_hStart),
        .player_load    (player_load),
        .game_won       (game_won),
        .time_left      (time_left)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_complete();
        level_complete = 1'b1;
        step();
        level_complete = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // Completes the current level: PLAY -> CELEBRATE -> LOAD -> next state.
    task automatic finish_level();
        pulse_complete();
        repeat (CELEBRATE_TICKS) do_tick();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        start = 1'b0;
        level_complete = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Reset state and table entry 0
        check("rst_level", level, 0);
        check("rst_vis", dest_visible, 0);
        check("rst_pload", player_load, 0);
        check("rst_won", game_won, 0);
        check("rst_time_left", time_left, 0);
        check("rst_dest_v", dest_vStartPos, 100);
        check("rst_dest_h", dest_hStartPos, 600);
        check("rst_color", dest_color, 1);
        check("rst_player_v", player_vStart, 400);
        check("rst_player_h", player_hStart, 50);

        pulse_start();
        check("start_pload", player_load, 1);
        check("start_level", level, 0);
        check("start_vis", dest_visible, 1);
        step();
        check("start_pload_one_clk", player_load, 0);

        pulse_start();
        check("play_start_ignored_pload", player_load, 0);
        check("play_start_ignored_level", level, 0);

        // level_complete wins over a coincident tick
        level_complete = 1'b1;
        tick = 1'b1;
        step();
        level_complete = 1'b0;
        tick = 1'b0;
        check("cel_enter_vis", dest_visible, 1);
        pulse_complete();
        check("cel_complete_ignored_vis", dest_visible, 1);

        do_tick();
        check("blink_t1", dest_visible, 1);
        step();
        check("blink_hold", dest_visible, 1);
        do_tick();
        check("blink_t2", dest_visible, 0);
        pulse_complete();
        check("blink_complete_ignored", dest_visible, 0);
        do_tick();
        check("blink_t3", dest_visible, 0);
        do_tick();
        check("load_no_pload", player_load, 0);
        check("load_level_old", level, 0);
        step();
        check("l1_pload", player_load, 1);
        check("l1_level", level, 1);
        check("l1_vis", dest_visible, 1);
        check("l1_dest_v", dest_vStartPos, 80);
        check("l1_dest_h", dest_hStartPos, 700);
        check("l1_color", dest_color, 2);
        check("l1_player_v", player_vStart, 420);
        check("l1_player_h", player_hStart, 60);
        step();
        check("l1_pload_one_clk", player_load, 0);

        // Ticks in PLAY must not blink: no queued completion re-entered CELEBRATE
        do_tick();
        do_tick();
        check("no_queued_complete_vis", dest_visible, 1);
        check("no_queued_complete_level", level, 1);

        finish_level();
        check("l2_pload", player_load, 1);
        check("l2_level", level, 2);
        check("l2_dest_v", dest_vStartPos, 60);
        check("l2_player_v", player_vStart, 300);

        finish_level();
        check("win_won", game_won, 1);
        check("win_vis", dest_visible, 0);
        check("win_pload", player_load, 0);
        check("win_level_sat", level, 2);
        pulse_complete();
        check("win_complete_ignored_won", game_won, 1);
        check("win_complete_ignored_level", level, 2);

        pulse_start();
        check("restart_level", level, 0);
        check("restart_won", game_won, 0);
        check("restart_pload", player_load, 1);
        check("restart_vis", dest_visible, 1);
        check("restart_dest_v", dest_vStartPos, 100);

        // Asynchronous reset mid-CELEBRATE at level 1
        finish_level();
        check("pre_rst_level", level, 1);
        pulse_complete();
        do_tick();
        rst = 1'b1;
        #2;
        check("async_rst_level", level, 0);
        check("async_rst_vis", dest_visible, 0);
        check("async_rst_pload", player_load, 0);
        check("async_rst_won", game_won, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_pload", player_load, 0);
        step();
        check("post_rst_idle_vis", dest_visible, 0);
        check("post_rst_idle_pload", player_load, 0);
        check("post_rst_dest_h", dest_hStartPos, 600);

`ifdef LEVEL_SEQ_TIMEOUT_EN
        pulse_start();
        check("to_load", time_left, 3);
        do_tick();
        check("to_dec1", time_left, 2);
        check("to_dec1_pload", player_load, 0);
        do_tick();
        check("to_dec2", time_left, 1);
        do_tick();
        check("to_expire_pload", player_load, 1);
        check("to_expire_reload", time_left, 3);
        check("to_expire_level", level, 0);
        check("to_expire_vis", dest_visible, 1);
        step();
        check("to_expire_pload_one_clk", player_load, 0);
        do_tick();
        do_tick();
        check("to_pre_tie", time_left, 1);
        level_complete = 1'b1;
        tick = 1'b1;
        step();
        level_complete = 1'b0;
        tick = 1'b0;
        check("to_tie_no_restart", player_load, 0);
        check("to_tie_time_held", time_left, 1);
        do_tick();
        do_tick();
        check("to_tie_in_celebrate", dest_visible, 0);
`else
        pulse_start();
        do_tick();
        do_tick();
        do_tick();
        check("no_timer_time_left", time_left, 0);
        check("no_timer_pload", player_load, 0);
        check("no_timer_level", level, 0);
        check("no_timer_vis", dest_visible, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
